// File: rtl/spi_master.sv
// SPI mode-0 master with Avalon-ST byte interfaces. Each accepted sink byte is shifted
// out MSB first while the byte returned on miso is presented on the source port.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       sysclk,
    input  logic       nreset,
    input  logic [7:0] stsinkdata,
    input  logic       stsinkvalid,
    output logic       stsinkready,
    output logic [7:0] stsourcedata,
    output logic       stsourcevalid,
    input  logic       stsourceready,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       nss,
    output logic       busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_e;

    state_e           r_state;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit;
    logic [GAP_W-1:0] r_gap;
    logic [6:0]       r_tx;
    logic [7:0]       r_rx;
    logic [7:0]       r_srcdata;
    logic             r_srcvalid;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_nss;

    logic             w_ready;
    logic             w_take;

    // Gated by nreset so the sink port is closed while reset is held, even though IDLE.
    assign w_ready = nreset & ((r_state == IDLE) | ((r_state == HOLD) & ~r_srcvalid));
    assign w_take  = stsinkvalid & w_ready;

    assign stsinkready   = w_ready;
    assign stsourcedata  = r_srcdata;
    assign stsourcevalid = r_srcvalid;
    assign sclk          = r_sclk;
    assign mosi          = r_mosi;
    assign nss           = r_nss;
    assign busy          = (r_state != IDLE);

    // NOTE: all state is updated with non-blocking assignments so every branch sees the
    // pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge sysclk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_gap      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_srcdata  <= '0;
            r_srcvalid <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_nss      <= 1'b1;
        end else if (w_take) begin
            // Entered from IDLE or HOLD; nss simply stays low on a back-to-back byte.
            r_state <= SHIFT;
            r_div   <= '0;
            r_bit   <= '0;
            r_tx    <= stsinkdata[6:0];
            r_mosi  <= stsinkdata[7];
            r_rx    <= '0;
            r_sclk  <= 1'b0;
            r_nss   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_nss  <= 1'b1;
                    r_mosi <= 1'b0;
                end
                SHIFT: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else if (!r_sclk) begin
                        r_div  <= '0;
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[6:0], miso};
                    end else begin
                        r_div  <= '0;
                        r_sclk <= 1'b0;
                        if (r_bit == 3'd7) begin
                            r_state    <= HOLD;
                            r_bit      <= '0;
                            r_mosi     <= 1'b0;
                            r_srcdata  <= r_rx;
                            r_srcvalid <= 1'b1;
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            r_mosi <= r_tx[6];
                            r_tx   <= {r_tx[5:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (r_srcvalid) begin
                        if (stsourceready) begin
                            r_srcvalid <= 1'b0;
                        end
                    end else begin
                        r_state <= GAP;
                        r_gap   <= '0;
                        r_nss   <= 1'b1;
                        r_mosi  <= 1'b0;
                    end
                end
                GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= IDLE;
                        r_gap   <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a frame-timeline model predicts every output each
// cycle, and directed sequences pin the model with hand-computed values.
module tb_spi_master;

    localparam int D = 2;
    localparam int G = 4;

    logic       sysclk;
    logic       nreset;
    logic [7:0] stsinkdata;
    logic       stsinkvalid;
    logic       stsinkready;
    logic [7:0] stsourcedata;
    logic       stsourcevalid;
    logic       stsourceready;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       nss;
    logic       busy;

    spi_master #(.CLK_DIV(D), .CS_GAP(G)) dut (
        .sysclk        (sysclk),
        .nreset        (nreset),
        .stsinkdata    (stsinkdata),
        .stsinkvalid   (stsinkvalid),
        .stsinkready   (stsinkready),
        .stsourcedata  (stsourcedata),
        .stsourcevalid (stsourcevalid),
        .stsourceready (stsourceready),
        .sclk          (sclk),
        .mosi          (mosi),
        .miso          (miso),
        .nss           (nss),
        .busy          (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: frame timeline ----------------
    typedef enum {M_IDLE, M_SHIFT, M_HOLD, M_GAP} mmode_e;
    mmode_e     m_mode = M_IDLE;
    int         m_t = 0;
    int         m_g = 0;
    logic [7:0] m_tx = '0;
    logic [7:0] m_slave = '0;
    logic [7:0] m_srcdata = '0;
    logic       m_srcvalid = 1'b0;
    logic [7:0] slave_next;

    always @(posedge sysclk or negedge nreset) begin
        if (!nreset) begin
            m_mode     <= M_IDLE;
            m_t        <= 0;
            m_g        <= 0;
            m_tx       <= '0;
            m_slave    <= '0;
            m_srcvalid <= 1'b0;
            m_srcdata  <= '0;
        end else begin
            case (m_mode)
                M_IDLE: if (stsinkvalid) begin
                    m_mode <= M_SHIFT; m_t <= 0; m_tx <= stsinkdata; m_slave <= slave_next;
                end
                M_SHIFT: if (m_t == 16 * D - 1) begin
                    m_mode <= M_HOLD; m_srcvalid <= 1'b1; m_srcdata <= m_slave;
                end else begin
                    m_t <= m_t + 1;
                end
                M_HOLD: if (m_srcvalid) begin
                    if (stsourceready) m_srcvalid <= 1'b0;
                end else if (stsinkvalid) begin
                    m_mode <= M_SHIFT; m_t <= 0; m_tx <= stsinkdata; m_slave <= slave_next;
                end else begin
                    m_mode <= M_GAP; m_g <= 0;
                end
                M_GAP: if (m_g == G - 1) m_mode <= M_IDLE; else m_g <= m_g + 1;
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare, slave miso, monitors ----------------
    int         cur_run = 0;
    int         last_run = 0;
    logic [7:0] src_log[$];

    always @(negedge sysclk) begin
        logic e_nss, e_sclk, e_busy, e_ready;
        int   bi;
        bi      = 7 - m_t / (2 * D);
        e_nss   = !(m_mode == M_SHIFT || m_mode == M_HOLD);
        e_sclk  = (m_mode == M_SHIFT) && ((m_t % (2 * D)) >= D);
        e_busy  = (m_mode != M_IDLE);
        e_ready = nreset && (m_mode == M_IDLE || (m_mode == M_HOLD && !m_srcvalid));
        check("nss", nss, e_nss);
        check("sclk", sclk, e_sclk);
        check("busy", busy, e_busy);
        check("sinkready", stsinkready, e_ready);
        check("srcvalid", stsourcevalid, m_srcvalid);
        check("srcdata", stsourcedata, m_srcdata);
        if (m_mode == M_SHIFT) check("mosi_shift", mosi, m_tx[bi]);
        else if (e_nss) check("mosi_nss_high", mosi, 1'b0);
        miso = (m_mode == M_SHIFT) ? m_slave[bi] : 1'b0;
        if (stsourcevalid && stsourceready) src_log.push_back(stsourcedata);
        if (!nss) cur_run = cur_run + 1;
        else begin
            if (cur_run > 0) last_run = cur_run;
            cur_run = 0;
        end
    end

    logic [15:0] mon_mosi = '0;
    int          pulses = 0;
    always @(posedge sclk) begin
        mon_mosi <= {mon_mosi[14:0], mosi};
        pulses   <= pulses + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (called just after a rising edge) ----------------
    task automatic drive_byte(input logic [7:0] d, input logic [7:0] s);
        int n;
        n = 0;
        stsinkdata  = d;
        slave_next  = s;
        stsinkvalid = 1'b1;
        while (n < 1000) begin
            @(negedge sysclk);
            if (stsinkready) break;
            n++;
        end
        check("sink_accept_in_time", 32'(n < 1000), 1);
        @(posedge sysclk); #1;
        stsinkvalid = 1'b0;
        stsinkdata  = 8'($urandom);
    endtask

    task automatic wait_srcvalid(output int low_cycles);
        int n;
        n = 0;
        low_cycles = 0;
        while (n < 500) begin
            @(negedge sysclk);
            if (stsourcevalid) break;
            if (!nss) low_cycles++;
            n++;
        end
        check("srcvalid_in_time", 32'(n < 500), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 500) begin
            @(negedge sysclk);
            if (!busy) break;
            n++;
        end
        check("idle_in_time", 32'(n < 500), 1);
        @(posedge sysclk); #1;
    endtask

    initial begin
        int low, p0, s0, gap, rdy, bad, n;
        logic [8:0] b0, b1;
        nreset        = 1'b0;
        stsinkdata    = '0;
        stsinkvalid   = 1'b0;
        stsourceready = 1'b0;
        slave_next    = '0;

        // Reset state
        repeat (3) @(negedge sysclk);
        #1;
        check("rst_nss", nss, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_sinkready", stsinkready, 0);
        check("rst_srcvalid", stsourcevalid, 0);
        check("rst_srcdata", stsourcedata, 8'h00);
        check("rst_busy", busy, 0);
        #2 nreset = 1'b1;
        #1 check("post_rst_ready", stsinkready, 1);
        @(posedge sysclk); #1;

        // 0xA5 out, slave returns 0x3C
        p0 = pulses;
        drive_byte(8'hA5, 8'h3C);
        wait_srcvalid(low);
        #1;
        check("a5_nss_low_cycles", low, 32);
        check("a5_sclk_pulses", pulses - p0, 8);
        check("a5_mosi_bits", mon_mosi[7:0], 8'hA5);
        check("a5_rx_data", stsourcedata, 8'h3C);
        check("a5_rx_valid", stsourcevalid, 1);

        // Accept, no follow-up byte: GAP of exactly G cycles, sink closed throughout
        @(posedge sysclk); #1;
        stsourceready = 1'b1;
        gap = 0; rdy = 0; n = 0;
        while (n < 100) begin
            @(negedge sysclk);
            if (!busy) break;
            if (nss) begin
                gap++;
                if (stsinkready) rdy++;
            end
            n++;
        end
        check("gap_cycles", gap, 4);
        check("gap_ready_cycles", rdy, 0);
        check("gap_then_ready", stsinkready, 1);
        @(posedge sysclk); #1;

        // Back-to-back 0x01, 0xFF with the source always ready
        p0 = pulses;
        s0 = src_log.size();
        drive_byte(8'h01, 8'h96);
        drive_byte(8'hFF, 8'h69);
        wait_idle();
        b0 = (src_log.size() > s0) ? {1'b0, src_log[s0]} : 9'h100;
        b1 = (src_log.size() > s0 + 1) ? {1'b0, src_log[s0 + 1]} : 9'h100;
        check("b2b_sclk_pulses", pulses - p0, 16);
        check("b2b_mosi_bits", mon_mosi, 16'h01FF);
        check("b2b_nss_continuous", 32'(last_run >= 65), 1);
        check("b2b_src_count", src_log.size() - s0, 2);
        check("b2b_src_first", b0, 9'h096);
        check("b2b_src_second", b1, 9'h069);

        // Source stalled with a second byte waiting
        stsourceready = 1'b0;
        s0 = src_log.size();
        drive_byte(8'h3C, 8'h81);
        stsinkvalid = 1'b1;
        stsinkdata  = 8'h7E;
        slave_next  = 8'h42;
        wait_srcvalid(low);
        bad = 0;
        repeat (10) begin
            @(negedge sysclk);
            if (nss || sclk || stsinkready || !stsourcevalid || stsourcedata != 8'h81) bad++;
        end
        check("stall_bad_cycles", bad, 0);
        @(posedge sysclk); #1;
        stsourceready = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge sysclk);
            if (stsinkready) break;
            n++;
        end
        check("stall_release_in_time", 32'(n < 100), 1);
        @(posedge sysclk); #1;
        stsinkvalid = 1'b0;
        wait_srcvalid(low);
        #1;
        b0 = (src_log.size() > s0) ? {1'b0, src_log[s0]} : 9'h100;
        check("stall_first_src", b0, 9'h081);
        check("stall_second_rx", stsourcedata, 8'h42);
        check("stall_mosi_bits", mon_mosi, 16'h3C7E);
        wait_idle();

        // Reset after 3 sclk pulses of 0xC3, then 0x5A
        p0 = pulses;
        drive_byte(8'hC3, 8'h55);
        n = 0;
        while (n < 200) begin
            @(negedge sysclk);
            if (pulses - p0 >= 3) break;
            n++;
        end
        #3 nreset = 1'b0;
        #1;
        check("midrst_nss", nss, 1);
        check("midrst_sclk", sclk, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", stsinkready, 0);
        check("midrst_srcvalid", stsourcevalid, 0);
        bad = 0;
        repeat (3) begin
            @(negedge sysclk);
            if (stsourcevalid) bad++;
        end
        check("midrst_no_valid", bad, 0);
        #3 nreset = 1'b1;
        #1 check("midrst_release_ready", stsinkready, 1);
        @(posedge sysclk); #1;
        p0 = pulses;
        drive_byte(8'h5A, 8'hE7);
        wait_srcvalid(low);
        #1;
        check("after_rst_rx", stsourcedata, 8'hE7);
        check("after_rst_pulses", pulses - p0, 8);
        check("after_rst_mosi", mon_mosi[7:0], 8'h5A);
        wait_idle();

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(posedge sysclk); #1;
            stsinkvalid   = ($urandom_range(0, 3) != 0);
            stsinkdata    = 8'($urandom);
            stsourceready = ($urandom_range(0, 2) != 0);
            slave_next    = 8'($urandom);
        end
        stsinkvalid   = 1'b0;
        stsourceready = 1'b1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: CLK_DIV, default 4, sysclk cycles per sclk half-period (legal >= 2).
REQ-002 Parameter: CS_GAP, default 4, sysclk cycles nss held high between frames.
REQ-003 Port: sysclk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: nreset  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 Port: stsinkdata  input  8  byte to transmit (Avalon-ST sink data).
REQ-006 Port: stsinkvalid  input  1  stsinkdata valid.
REQ-007 Port: stsinkready  output  1  block accepts stsinkdata this cycle.
REQ-008 Port: stsourcedata  output  8  byte received on miso (Avalon-ST source data).
REQ-009 Port: stsourcevalid  output  1  stsourcedata valid.
REQ-010 Port: stsourceready  input  1  downstream accepts stsourcedata.
REQ-011 Port: sclk  output  1  SPI clock, mode 0 (idle low).
REQ-012 Port: mosi  output  1  serial data out, MSB first.
REQ-013 Port: miso  input  1  serial data in, MSB first.
REQ-014 Port: nss  output  1  active-low slave select.
REQ-015 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-016 States SHALL be IDLE, SHIFT, HOLD, GAP; encoding free.
REQ-017 stsinkready SHALL be 1 only in IDLE, or in HOLD with stsourcevalid=0; transfer occurs on stsinkvalid&&stsinkready.
REQ-018 IDLE: on transfer, next cycle nss=0, sclk=0, mosi=data[7], shift register loaded, bit count 0, go SHIFT.
REQ-019 SHIFT: each bit = CLK_DIV cycles sclk low then CLK_DIV cycles sclk high; miso sampled into LSB of shift register on the cycle sclk rises; mosi advances to next bit on the cycle sclk falls.
REQ-020 After the 8th falling edge SHIFT SHALL go HOLD; one byte occupies exactly 16*CLK_DIV cycles with nss low.
REQ-021 On entry to HOLD the 8 received bits SHALL be written to stsourcedata and stsourcevalid set to 1.
REQ-022 stsourcevalid SHALL clear the cycle after stsourcevalid&&stsourceready; stsourcedata SHALL hold stable while valid and unaccepted.
REQ-023 HOLD, each cycle: stsourcevalid=1 -> stay (nss low, sclk low); else stsinkvalid=1 -> accept, load next byte, go SHIFT with nss kept low (no nss glitch); else go GAP.
REQ-024 Simultaneous source accept and sink valid in HOLD: source clears this cycle, sink accepted the following cycle.
REQ-025 GAP: nss=1, sclk=0, mosi=0, stsinkready=0 for exactly CS_GAP cycles, then IDLE.
REQ-026 mosi SHALL be 0 whenever nss=1.
REQ-027 Changes on stsinkdata while not transferred SHALL have no effect.
REQ-028 Bit and divider counters SHALL wrap only via state transitions; no partial bytes emitted except on reset.

Reset
REQ-029 nreset=0 SHALL immediately force state IDLE, nss=1, sclk=0, mosi=0, stsinkready=0, stsourcevalid=0, stsourcedata=0, busy=0, counters 0.
REQ-030 Reset mid-byte SHALL discard the partial byte; no stsourcevalid pulse follows.
REQ-031 First cycle after nreset deasserts: stsinkready=1 (IDLE).

Verification (CLK_DIV=2, CS_GAP=4)
REQ-032 Send 0xA5, slave model drives 0x3C -> mosi 1,0,1,0,0,1,0,1 at rising edges; nss low 32 cycles; stsourcedata=0x3C, stsourcevalid=1.
REQ-033 Send 0x01 then 0xFF back-to-back, stsourceready=1 -> nss low continuously 64+1 cycles, 16 sclk pulses, two source bytes in order.
REQ-034 Hold stsourceready=0 after first byte with second byte valid -> nss stays low, sclk idle, stsinkready=0 until source accepted; then second byte sent.
REQ-035 stsinkvalid=0 after byte -> nss high exactly 4 cycles, stsinkready=0 during GAP, then 1.
REQ-036 Assert nreset after 3 sclk pulses of 0xC3 -> nss=1, sclk=0, mosi=0 same cycle; no stsourcevalid; next byte 0x5A transfers correctly.
